// File: rtl/ld_project.sv
// ld_project: 5-bit ID access controller.
// Keeps a 32-entry registration bitmap driven by enroll / verify / delete /
// clear-all commands (priority s3 > s2 > s1 > s0). A verify reports the ID as
// last granted or last denied, steps a saturating counter and raises a
// one-cycle pulse on fgp or frp.
// Optional build macro LD_PROJECT_LOCKOUT_EN: the third deny in a row locks
// out every verify for LOCK_CYCLES clocks.
module ld_project #(
   parameter int CNT_MAX     = 31,
   parameter int LOCK_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic s0,
   input  logic s1,
   input  logic s2,
   input  logic s3,
   input  logic i0,
   input  logic i1,
   input  logic i2,
   input  logic i3,
   input  logic i4,
   output logic fgt0,
   output logic fgt1,
   output logic fgt2,
   output logic fgt3,
   output logic fgt4,
   output logic frt0,
   output logic frt1,
   output logic frt2,
   output logic frt3,
   output logic frt4,
   output logic fgc0,
   output logic fgc1,
   output logic fgc2,
   output logic fgc3,
   output logic fgc4,
   output logic frc0,
   output logic frc1,
   output logic frc2,
   output logic frc3,
   output logic frc4,
   output logic fgp,
   output logic frp
);

   localparam logic [4:0] CMAX = 5'(CNT_MAX);

   logic [4:0]  id;
   logic [31:0] reg_map;
   logic [4:0]  fgt, frt, fgc, frc;
   logic        fgp_q, frp_q;
   logic        do_clr, do_del, do_ver, do_enr;
   logic        locked, hit, grant, deny;

   assign id = {i4, i3, i2, i1, i0};

`ifdef LD_PROJECT_LOCKOUT_EN
   localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

   logic [1:0]    dcnt;      // consecutive denies seen so far
   logic [LW-1:0] lock_cnt;  // clocks of lockout remaining

   assign locked = (lock_cnt != '0);

   // Consecutive-deny tracking and lockout timer. Denies issued while locked
   // do not count toward a new lockout; the timer simply runs down.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt     <= 2'd0;
         lock_cnt <= '0;
      end else if (do_clr) begin
         dcnt     <= 2'd0;
         lock_cnt <= '0;
      end else begin
         if (locked)
            lock_cnt <= lock_cnt - LW'(1);
         if (grant)
            dcnt <= 2'd0;
         else if (deny && !locked) begin
            if (dcnt == 2'd2) begin
               dcnt     <= 2'd0;
               lock_cnt <= LW'(LOCK_CYCLES);
            end else begin
               dcnt <= dcnt + 2'd1;
            end
         end
      end
   end
`else
   // Lockout parameter has no effect in this build.
   logic unused_lock;
   assign unused_lock = ^LOCK_CYCLES;
   assign locked      = 1'b0;
`endif

   // Command decode with fixed priority, and the verify outcome.
   always_comb begin
      do_clr = s3;
      do_del = !s3 && s2;
      do_ver = !s3 && !s2 && s1;
      do_enr = !s3 && !s2 && !s1 && s0;
      hit    = reg_map[id] && !locked;
      grant  = do_ver && hit;
      deny   = do_ver && !hit;
   end

   // Bitmap, indicator registers, saturating counters and result pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_map <= '0;
         fgt     <= '0;
         frt     <= '0;
         fgc     <= '0;
         frc     <= '0;
         fgp_q   <= 1'b0;
         frp_q   <= 1'b0;
      end else begin
         fgp_q <= grant;
         frp_q <= deny;
         if (do_clr) begin
            reg_map <= '0;
            fgt     <= '0;
            frt     <= '0;
            fgc     <= '0;
            frc     <= '0;
         end else if (do_del) begin
            reg_map[id] <= 1'b0;
         end else if (do_enr) begin
            reg_map[id] <= 1'b1;
         end else if (grant) begin
            fgt <= id;
            if (fgc != CMAX)
               fgc <= fgc + 5'd1;
         end else if (deny) begin
            frt <= id;
            if (frc != CMAX)
               frc <= frc + 5'd1;
         end
      end
   end

   assign {fgt4, fgt3, fgt2, fgt1, fgt0} = fgt;
   assign {frt4, frt3, frt2, frt1, frt0} = frt;
   assign {fgc4, fgc3, fgc2, fgc1, fgc0} = fgc;
   assign {frc4, frc3, frc2, frc1, frc0} = frc;
   assign fgp = fgp_q;
   assign frp = frp_q;

endmodule

// File: tb/tb_ld_project.sv
// Directed self-checking bench for ld_project.
module tb_ld_project;

   localparam logic [3:0] IDLE = 4'b0000;
   localparam logic [3:0] ENR  = 4'b0001;
   localparam logic [3:0] VER  = 4'b0010;
   localparam logic [3:0] DEL  = 4'b0100;
   localparam logic [3:0] CLR  = 4'b1000;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic s0 = 0, s1 = 0, s2 = 0, s3 = 0;
   logic i0 = 0, i1 = 0, i2 = 0, i3 = 0, i4 = 0;
   logic fgt0, fgt1, fgt2, fgt3, fgt4;
   logic frt0, frt1, frt2, frt3, frt4;
   logic fgc0, fgc1, fgc2, fgc3, fgc4;
   logic frc0, frc1, frc2, frc3, frc4;
   logic fgp, frp;
   logic [4:0] fgt, frt, fgc, frc;

   int checks = 0;
   int failures = 0;

   assign fgt = {fgt4, fgt3, fgt2, fgt1, fgt0};
   assign frt = {frt4, frt3, frt2, frt1, frt0};
   assign fgc = {fgc4, fgc3, fgc2, fgc1, fgc0};
   assign frc = {frc4, frc3, frc2, frc1, frc0};

   always #5 clk = ~clk;

   ld_project dut (
      .clk(clk), .rst_n(rst_n),
      .s0(s0), .s1(s1), .s2(s2), .s3(s3),
      .i0(i0), .i1(i1), .i2(i2), .i3(i3), .i4(i4),
      .fgt0(fgt0), .fgt1(fgt1), .fgt2(fgt2), .fgt3(fgt3), .fgt4(fgt4),
      .frt0(frt0), .frt1(frt1), .frt2(frt2), .frt3(frt3), .frt4(frt4),
      .fgc0(fgc0), .fgc1(fgc1), .fgc2(fgc2), .fgc3(fgc3), .fgc4(fgc4),
      .frc0(frc0), .frc1(frc1), .frc2(frc2), .frc3(frc3), .frc4(frc4),
      .fgp(fgp), .frp(frp)
   );

   // Apply one command for one edge, then sample 1 time unit after the edge.
   task automatic cmd(input logic [3:0] c, input logic [4:0] id);
      {s3, s2, s1, s0} = c;
      {i4, i3, i2, i1, i0} = id;
      @(posedge clk);
      #1;
      {s3, s2, s1, s0} = IDLE;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({fgt, frt, fgc, frc, fgp, frp} !== 22'd0) begin
         failures++;
         $display("FAIL reset_outputs: got fgt=%0d frt=%0d fgc=%0d frc=%0d fgp=%b frp=%b, want all 0",
                  fgt, frt, fgc, frc, fgp, frp);
      end
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cmd(IDLE, 5'd0);
         checks++;
         if ({fgt, frt, fgc, frc, fgp, frp} !== 22'd0) begin
            failures++;
            $display("FAIL idle_hold[%0d]: got fgt=%0d frt=%0d fgc=%0d frc=%0d fgp=%b frp=%b, want all 0",
                     k, fgt, frt, fgc, frc, fgp, frp);
         end
      end
   endtask

   task automatic test_enroll_verify;
      cmd(ENR, 5'd31);
      checks++;
      if (fgp !== 1'b0 || frp !== 1'b0) begin
         failures++;
         $display("FAIL enroll_no_pulse: got fgp=%b frp=%b, want 0 0", fgp, frp);
      end
      cmd(VER, 5'd31);
      checks++;
      if (fgp !== 1'b1 || frp !== 1'b0 || fgt !== 5'd31 || fgc !== 5'd1 || frc !== 5'd0) begin
         failures++;
         $display("FAIL verify_grant: got fgp=%b frp=%b fgt=%0d fgc=%0d frc=%0d, want 1 0 31 1 0",
                  fgp, frp, fgt, fgc, frc);
      end
      cmd(IDLE, 5'd0);
      checks++;
      if (fgp !== 1'b0 || fgt !== 5'd31 || fgc !== 5'd1) begin
         failures++;
         $display("FAIL grant_one_cycle: got fgp=%b fgt=%0d fgc=%0d, want 0 31 1", fgp, fgt, fgc);
      end
   endtask

   task automatic test_deny;
      cmd(VER, 5'd21);
      checks++;
      if (frp !== 1'b1 || fgp !== 1'b0 || frt !== 5'd21 || frc !== 5'd1 || fgt !== 5'd31) begin
         failures++;
         $display("FAIL verify_deny: got frp=%b fgp=%b frt=%0d frc=%0d fgt=%0d, want 1 0 21 1 31",
                  frp, fgp, frt, frc, fgt);
      end
   endtask

   task automatic test_back_to_back;
      cmd(VER, 5'd31);
      checks++;
      if (fgp !== 1'b1 || fgc !== 5'd2) begin
         failures++;
         $display("FAIL b2b_first: got fgp=%b fgc=%0d, want 1 2", fgp, fgc);
      end
      cmd(VER, 5'd31);
      checks++;
      if (fgp !== 1'b1 || frp !== 1'b0 || fgc !== 5'd3) begin
         failures++;
         $display("FAIL b2b_second: got fgp=%b frp=%b fgc=%0d, want 1 0 3", fgp, frp, fgc);
      end
      cmd(VER, 5'd0);
      checks++;
      if (frp !== 1'b1 || fgp !== 1'b0 || frt !== 5'd0 || frc !== 5'd2) begin
         failures++;
         $display("FAIL b2b_deny_id0: got frp=%b fgp=%b frt=%0d frc=%0d, want 1 0 0 2", frp, fgp, frt, frc);
      end
      cmd(ENR, 5'd0);
      cmd(VER, 5'd0);
      checks++;
      if (fgp !== 1'b1 || fgt !== 5'd0 || fgc !== 5'd4 || frt !== 5'd0) begin
         failures++;
         $display("FAIL grant_id0: got fgp=%b fgt=%0d fgc=%0d frt=%0d, want 1 0 4 0", fgp, fgt, fgc, frt);
      end
   endtask

   task automatic test_delete_priority;
      cmd(ENR, 5'd5);
      cmd(DEL | VER, 5'd5);
      checks++;
      if (fgp !== 1'b0 || frp !== 1'b0 || fgc !== 5'd4 || frc !== 5'd2) begin
         failures++;
         $display("FAIL delete_wins: got fgp=%b frp=%b fgc=%0d frc=%0d, want 0 0 4 2", fgp, frp, fgc, frc);
      end
      cmd(VER, 5'd5);
      checks++;
      if (frp !== 1'b1 || fgp !== 1'b0 || frt !== 5'd5 || frc !== 5'd3) begin
         failures++;
         $display("FAIL verify_deleted: got frp=%b fgp=%b frt=%0d frc=%0d, want 1 0 5 3", frp, fgp, frt, frc);
      end
   endtask

   task automatic test_saturation_clear;
      logic [4:0] exp;
      cmd(CLR, 5'd0);
      checks++;
      if ({fgt, frt, fgc, frc, fgp, frp} !== 22'd0) begin
         failures++;
         $display("FAIL clear_first: got fgt=%0d frt=%0d fgc=%0d frc=%0d, want all 0", fgt, frt, fgc, frc);
      end
      cmd(ENR, 5'd31);
      for (int k = 0; k < 33; k++) begin
         cmd(VER, 5'd9);
         exp = (k >= 30) ? 5'd31 : 5'(k + 1);
         checks++;
         if (frc !== exp || frp !== 1'b1 || frt !== 5'd9) begin
            failures++;
            $display("FAIL deny_sat[%0d]: got frc=%0d frp=%b frt=%0d, want %0d 1 9", k, frc, frp, frt, exp);
         end
      end
      cmd(CLR, 5'd0);
      checks++;
      if ({fgt, frt, fgc, frc, fgp, frp} !== 22'd0) begin
         failures++;
         $display("FAIL clear_all: got fgt=%0d frt=%0d fgc=%0d frc=%0d fgp=%b frp=%b, want all 0",
                  fgt, frt, fgc, frc, fgp, frp);
      end
      cmd(VER, 5'd31);
      checks++;
      if (frp !== 1'b1 || fgp !== 1'b0 || frt !== 5'd31 || frc !== 5'd1) begin
         failures++;
         $display("FAIL map_cleared: got frp=%b fgp=%b frt=%0d frc=%0d, want 1 0 31 1", frp, fgp, frt, frc);
      end
   endtask

   task automatic test_async_reset;
      cmd(CLR, 5'd0);
      cmd(ENR, 5'd7);
      for (int k = 0; k < 3; k++) cmd(VER, 5'd7);
      checks++;
      if (fgc !== 5'd3 || fgt !== 5'd7) begin
         failures++;
         $display("FAIL async_setup: got fgc=%0d fgt=%0d, want 3 7", fgc, fgt);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({fgt, frt, fgc, frc, fgp, frp} !== 22'd0) begin
         failures++;
         $display("FAIL async_reset: got fgt=%0d frt=%0d fgc=%0d frc=%0d fgp=%b frp=%b, want all 0",
                  fgt, frt, fgc, frc, fgp, frp);
      end
      @(negedge clk) rst_n = 1'b1;
      cmd(VER, 5'd7);
      checks++;
      if (frp !== 1'b1 || fgp !== 1'b0 || frt !== 5'd7) begin
         failures++;
         $display("FAIL async_map_cleared: got frp=%b fgp=%b frt=%0d, want 1 0 7", frp, fgp, frt);
      end
   endtask

`ifdef LD_PROJECT_LOCKOUT_EN
   task automatic test_lockout;
      cmd(CLR, 5'd0);
      cmd(ENR, 5'd31);
      for (int k = 0; k < 3; k++) cmd(VER, 5'd2);
      cmd(VER, 5'd31);
      checks++;
      if (frp !== 1'b1 || fgp !== 1'b0 || frt !== 5'd31 || frc !== 5'd4) begin
         failures++;
         $display("FAIL lockout_deny: got frp=%b fgp=%b frt=%0d frc=%0d, want 1 0 31 4", frp, fgp, frt, frc);
      end
      for (int k = 0; k < 8; k++) cmd(IDLE, 5'd0);
      cmd(VER, 5'd31);
      checks++;
      if (fgp !== 1'b1 || frp !== 1'b0 || fgt !== 5'd31 || fgc !== 5'd1) begin
         failures++;
         $display("FAIL lockout_end: got fgp=%b frp=%b fgt=%0d fgc=%0d, want 1 0 31 1", fgp, frp, fgt, fgc);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_enroll_verify();
      test_deny();
      test_back_to_back();
      test_delete_priority();
      test_saturation_clear();
      test_async_reset();
`ifdef LD_PROJECT_LOCKOUT_EN
      test_lockout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ld_project.md
Name: ld_project

Overview:
- 5-bit ID access controller: 32-entry registration bitmap, enroll/verify/delete/clear commands.
- Green/red indicator outputs report the last granted and last denied ID, saturating grant and deny counters, and one-cycle grant/deny pulses.
- Stand-alone lab-project top level.
- Single clock; all state registered.

Parameters:
- CNT_MAX, 31, saturation value of the fgc/frc counters; must fit in 5 bits.
- LOCK_CYCLES, 8, lockout length in clocks; used only with LOCKOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s0  input  1  enroll command.
- s1  input  1  verify command.
- s2  input  1  delete command.
- s3  input  1  clear-all command.
- i0..i4  input  1 each  ID bits; i0 is LSB; ID = {i4,i3,i2,i1,i0}.
- fgt0..fgt4  output  1 each  last granted ID, fgt0 is LSB.
- frt0..frt4  output  1 each  last denied ID, frt0 is LSB.
- fgc0..fgc4  output  1 each  grant counter, fgc0 is LSB.
- frc0..frc4  output  1 each  deny counter, frc0 is LSB.
- fgp  output  1  grant pulse.
- frp  output  1  deny pulse.
- Port order in the module header is exactly as listed above.

Behaviour:
Reset and timing:
- Reset is asynchronous and active-low on rst_n.
- During reset: bitmap reg_map[31:0] = 0; fgt, frt, fgc, frc = 0; fgp = 0; frp = 0.
- Commands are sampled on each rising clk edge. Results are visible after that same edge (latency 1 edge, no pipelining).

Command priority (one command per cycle): s3 > s2 > s1 > s0 > idle.
- s3=1: clear all. reg_map, fgt, frt, fgc and frc all go to 0; fgp = frp = 0.
- s2=1: delete. reg_map[ID] <= 0. Deleting an unenrolled ID is legal and has no other effect.
- s1=1, verify, grant case (reg_map[ID]=1): fgt <= ID; fgc <= fgc+1, saturating at CNT_MAX; fgp = 1 for this cycle only.
- s1=1, verify, deny case (reg_map[ID]=0): frt <= ID; frc <= frc+1, saturating at CNT_MAX; frp = 1 for this cycle only.
- s0=1: enroll. reg_map[ID] <= 1. Re-enrolling an enrolled ID is a no-op.
- All s* = 0: idle. State holds; fgp = frp = 0.

Pulses and holding:
- fgp and frp are registered pulses, high for exactly one cycle per verify.
- fgp and frp are never both 1 in the same cycle.
- Back-to-back verifies give back-to-back pulses.
- fgt, frt, fgc and frc hold their values until updated by a verify or cleared by s3 or reset.

Boundaries:
- Enroll or verify of ID 0 and ID 31 works like any other ID.
- A counter at 31 stays at 31; it never wraps.
- A verify issued in the cycle after an enroll of the same ID sees the updated bitmap.
- Reset asserted mid-sequence clears everything immediately, without waiting for a clock edge.

Optional Feature:
- Macro: LD_PROJECT_LOCKOUT_EN.
- Defined:
  - A 2-bit consecutive-deny counter counts denied verifies in a row.
  - The 3rd consecutive deny starts a lockout of LOCK_CYCLES clocks.
  - During lockout every verify is denied: frp pulses, frc and frt update, and the bitmap is not consulted.
  - Any grant resets the consecutive-deny counter.
  - s3 or reset clears the counter and ends any lockout.
  - Enroll and delete still function during lockout.
- Undefined: no lockout logic; verify behaves purely as described in Behaviour.

Test Plan:
- Reset then idle: rst_n low then high, all s*=0 -> all outputs 0; fgp and frp never pulse.
- Enroll then verify: s0=1, ID=31 (i=11111); next cycle s1=1, ID=31 -> fgp=1 for one cycle, fgt=31, fgc=1, frc=0.
- Verify unenrolled: s1=1, ID=21 (i4..i0=10101) -> frp=1, frt=21, frc=1; fgt unchanged.
- Delete and priority: enroll 5; then s2=1 and s1=1 together with ID=5 -> delete wins, no pulse; next cycle verify ID=5 -> deny, frt=5.
- Saturation and clear: 33 denied verifies -> frc=31 after the 31st and stays 31; then s3=1 -> all counters and registers 0; verify of previously enrolled ID 31 is denied.
- Async reset: assert rst_n low between clock edges with fgc=3 -> outputs drop to 0 immediately, before the next edge.
- Lockout (LD_PROJECT_LOCKOUT_EN defined): 3 denies in a row, then verify of enrolled ID 31 within 8 cycles -> frp=1; the same verify after the lockout -> fgp=1.
